// File: rtl/uart_txq_if.sv
// Byte-stream handshake into the UART transmit queue.
// The producer drives din/din_valid; the queue answers with din_ready.
interface uart_txq_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/uart_txq.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a gap-free LSB-first serializer.
// Define UART_TXQ_PARITY_EN to insert an even-parity bit (8E1 frames).
//
// state  | meaning
// IDLE   | line idle high, waiting for a queued byte
// START  | start bit (low)
// DATA   | eight data bits, LSB first
// PARITY | even parity of the byte (UART_TXQ_PARITY_EN builds only)
// STOP   | stop bit (high); pops the next byte at its end when one is queued
module uart_txq #(
  parameter int BAUD_MULT = 10416,
  parameter int DEPTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_txq_if.slave              in_if,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL     = (AW + 1)'(DEPTH);
  localparam logic [AW:0]     LVL_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [15:0]     BCNT_MAX = 16'(BAUD_MULT - 1);

`ifdef UART_TXQ_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t        state, state_nx;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [7:0]    sh, sh_nx;
  logic [2:0]    bidx, bidx_nx;
  logic [15:0]   bcnt, bcnt_nx;
  logic          tx_nx;
  logic          pop, wr, bit_end, have_byte;
`ifdef UART_TXQ_PARITY_EN
  logic          par, par_nx;
`endif

  // Ready comes from the registered level only, so a pop on a full cycle
  // never opens a same-cycle write.
  assign in_if.din_ready = (level != FULL);
  assign wr              = in_if.din_valid && in_if.din_ready;
  assign busy            = (state != S_IDLE);
  assign bit_end         = (bcnt == BCNT_MAX);
  assign have_byte       = (level != '0);

  always_comb begin
    state_nx = state;
    sh_nx    = sh;
    bidx_nx  = bidx;
    bcnt_nx  = bcnt + 16'd1;
    tx_nx    = tx;
    pop      = 1'b0;
`ifdef UART_TXQ_PARITY_EN
    par_nx   = par;
`endif
    case (state)
      S_IDLE: begin
        bcnt_nx = '0;
        if (have_byte) begin
          pop      = 1'b1;
          state_nx = S_START;
          sh_nx    = mem[rptr];
          tx_nx    = 1'b0;
`ifdef UART_TXQ_PARITY_EN
          par_nx   = ^mem[rptr];
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_nx = S_DATA;
          tx_nx    = sh[0];
          bidx_nx  = '0;
          bcnt_nx  = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bcnt_nx = '0;
          if (bidx == 3'd7) begin
`ifdef UART_TXQ_PARITY_EN
            state_nx = S_PARITY;
            tx_nx    = par;
`else
            state_nx = S_STOP;
            tx_nx    = 1'b1;
`endif
          end else begin
            sh_nx   = {1'b0, sh[7:1]};
            bidx_nx = bidx + 3'd1;
            tx_nx   = sh[1];
          end
        end
      end
`ifdef UART_TXQ_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_nx = S_STOP;
          tx_nx    = 1'b1;
          bcnt_nx  = '0;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          bcnt_nx = '0;
          // Popping here rather than via IDLE keeps consecutive frames gap-free.
          if (have_byte) begin
            pop      = 1'b1;
            state_nx = S_START;
            sh_nx    = mem[rptr];
            tx_nx    = 1'b0;
`ifdef UART_TXQ_PARITY_EN
            par_nx   = ^mem[rptr];
`endif
          end else begin
            state_nx = S_IDLE;
            tx_nx    = 1'b1;
          end
        end
      end
      default: begin
        state_nx = S_IDLE;
        tx_nx    = 1'b1;
        bcnt_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      tx    <= 1'b1;
      sh    <= '0;
      bidx  <= '0;
      bcnt  <= '0;
`ifdef UART_TXQ_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      tx    <= tx_nx;
      sh    <= sh_nx;
      bidx  <= bidx_nx;
      bcnt  <= bcnt_nx;
`ifdef UART_TXQ_PARITY_EN
      par   <= par_nx;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr)  wptr <= wptr + PTR_ONE;
      if (pop) rptr <= rptr + PTR_ONE;
      case ({wr, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: reset clears the pointers, which empties the queue.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= in_if.din;
  end

endmodule

// File: tb/tb_uart_txq.sv
// Self-checking bench for uart_txq: directed pushes, a scoreboard of expected bytes,
// and a line monitor that decodes every frame bit-by-bit against the scoreboard.
module tb_uart_txq;
  localparam int BM    = 16;
  localparam int DEPTH = 4;
`ifdef UART_TXQ_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME_CLK = NB * BM;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx, busy;
  logic [2:0] level;

  uart_txq_if bus();

  uart_txq #(.BAUD_MULT(BM), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .in_if (bus),
    .tx    (tx),
    .busy  (busy),
    .level (level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0] exp_q[$];
  int         start_q[$];
  int         frames = 0;
  logic [2:0] lvl_log[$];
  bit         log_en = 1'b0;
  logic [2:0] lvl_prev = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (log_en && level !== lvl_prev) begin
      lvl_log.push_back(level);
      lvl_prev = level;
    end
  end

  // Line monitor: one frame per falling edge seen outside reset.
  logic [7:0]    mon_b;
  logic [NB-1:0] mon_fb;
  bit            mon_abort;
  int            mon_ones;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        start_q.push_back(cyc);
        check("frame_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        mon_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        mon_fb = '1;
        mon_fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) mon_fb[1 + i] = mon_b[i];
`ifdef UART_TXQ_PARITY_EN
        mon_fb[9] = ^mon_b;
`endif
        mon_abort = 1'b0;
        for (int bi = 0; bi < NB && !mon_abort; bi++) begin
          mon_ones = 0;
          for (int c = 0; c < BM && !mon_abort; c++) begin
            if (bi != 0 || c != 0) @(negedge clk);
            if (rst) mon_abort = 1'b1;
            else mon_ones += int'(tx);
          end
          if (!mon_abort)
            check($sformatf("byte%02h_bit%0d_high_clks", mon_b, bi), mon_ones, mon_fb[bi] ? BM : 0);
        end
        if (!mon_abort) frames++;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    logic r;
    int k;
    bus.din = b;
    bus.din_valid = 1'b1;
    k = 0;
    do begin
      r = bus.din_ready;
      if (level == 3'd4) check("ready_low_when_full", {31'd0, r}, 32'd0);
      @(posedge clk); #1;
      k++;
    end while (!r && k < 2000);
    check("accept_in_budget", {31'd0, r}, 32'd1);
    if (r) exp_q.push_back(b);
    bus.din_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((busy !== 1'b0 || level !== 3'd0) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("idle_in_budget", {31'd0, (busy !== 1'b0 || level !== 3'd0)}, 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    check("scoreboard_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [2:0] lv_exp[4];
  int quiet_ones, quiet_busy;

  initial begin
    bus.din = 8'h00;
    bus.din_valid = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_level", {29'd0, level}, 32'd0);
      check("rst_ready", {31'd0, bus.din_ready}, 32'd1);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_tx", {31'd0, tx}, 32'd1);
    check("post_rst_ready", {31'd0, bus.din_ready}, 32'd1);

    // Single byte from idle: latency and end-of-frame edge.
    send(8'h45);
    check("accept_level", {29'd0, level}, 32'd1);
    check("accept_tx_still_high", {31'd0, tx}, 32'd1);
    check("accept_busy_low", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("start_tx_low", {31'd0, tx}, 32'd0);
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_level", {29'd0, level}, 32'd0);
    repeat (FRAME_CLK - 1) begin @(posedge clk); #1; end
    check("stop_last_clk_busy", {31'd0, busy}, 32'd1);
    check("stop_last_clk_tx", {31'd0, tx}, 32'd1);
    @(posedge clk); #1;
    check("frame_end_busy", {31'd0, busy}, 32'd0);
    check("frame_end_tx", {31'd0, tx}, 32'd1);
    wait_idle(50);
    check("frames_single", frames, 32'd1);

    // Back-to-back: 0xA5 goes out first while 0x45 and 0xD6 queue up behind it.
    start_q.delete();
    lvl_log.delete();
    lvl_prev = '0;
    log_en = 1'b1;
    send(8'hA5);
    send(8'h45);
    send(8'hD6);
    wait_idle(4 * FRAME_CLK);
    log_en = 1'b0;
    check("pair_frames", frames, 32'd4);
    check("pair_start_count", start_q.size(), 32'd3);
    check("gap_a5_45", start_q[1] - start_q[0], FRAME_CLK);
    check("gap_45_d6", start_q[2] - start_q[1], FRAME_CLK);
    lv_exp = '{3'd1, 3'd2, 3'd1, 3'd0};
    check("level_trace_len", lvl_log.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("level_trace_%0d", i), {29'd0, lvl_log[i]}, {29'd0, lv_exp[i]});

    // Fill the 4-deep FIFO behind a running frame.
    for (int v = 1; v <= 6; v++) begin
      send(8'(v));
      if (v == 5) begin
        check("full_level", {29'd0, level}, 32'd4);
        check("full_ready", {31'd0, bus.din_ready}, 32'd0);
      end
    end
    wait_idle(8 * FRAME_CLK);
    check("full_frames", frames, 32'd10);

    // Reset during data bit 3 of 0xD6 with two bytes queued.
    send(8'hD6);
    send(8'h11);
    send(8'h22);
    check("queued_two", {29'd0, level}, 32'd2);
    repeat (4 * BM + BM / 2 - 2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tx", {31'd0, tx}, 32'd1);
    check("async_rst_level", {29'd0, level}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_ready", {31'd0, bus.din_ready}, 32'd1);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    quiet_ones = 0;
    quiet_busy = 0;
    repeat (3 * FRAME_CLK) begin
      @(negedge clk);
      quiet_ones += int'(tx);
      quiet_busy += int'(busy);
    end
    check("quiet_tx_high_clks", quiet_ones, 3 * FRAME_CLK);
    check("quiet_busy_clks", quiet_busy, 32'd0);
    check("quiet_level", {29'd0, level}, 32'd0);
    check("aborted_frame_not_counted", frames, 32'd10);
    #1;
    send(8'h3C);
    wait_idle(2 * FRAME_CLK);
    check("post_rst_frames", frames, 32'd11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
